// File: rtl/pixel_clip_fifo.sv
// Clips pixels from a circle drawer to the screen and buffers them for a VGA adapter.
// Optional macro PIXEL_CLIP_STATS_EN adds a saturating clip_count output.
module pixel_clip_fifo #(
    parameter int DEPTH = 8,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_plot,
    input  logic       in_done,
    input  logic       out_ready,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_colour,
    output logic       out_plot,
    output logic       out_done,
    output logic       overflow
`ifdef PIXEL_CLIP_STATS_EN
    ,
    output logic [15:0] clip_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [7:0]    X_LIM   = 8'(X_MAX);
    localparam logic [6:0]    Y_LIM   = 7'(Y_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic [17:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    state_t        state, state_nxt;
    logic          in_range, accept, pop, full, push, drop, bypass;
    logic [17:0]   in_word, head_word;

    always_comb begin
        in_word    = {in_x, in_y, in_colour};
        in_range   = (in_x <= X_LIM) && (in_y <= Y_LIM);
        accept     = in_plot && in_range;
        pop        = out_plot && out_ready;
        full       = (count == FULL);
        push       = accept && (!full || pop);
        drop       = accept && full && !pop;
        rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
        // When the queue is empty after this cycle's pop, the new head is the pixel arriving now.
        bypass    = (count == '0) || ((count == CNT_ONE) && pop);
        head_word = bypass ? in_word : mem[rd_ptr_nxt];

        state_nxt = state;
        case (state)
            IDLE:    if (in_done) state_nxt = DRAIN;
                     else if (in_plot) state_nxt = RUN;
            RUN:     if (in_done) state_nxt = DRAIN;
            DRAIN:   if ((count == '0) && !push) state_nxt = DONE;
            DONE:    if (!in_done) state_nxt = IDLE;
                     else if (push) state_nxt = DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            out_plot   <= 1'b0;
            out_done   <= 1'b0;
            overflow   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_colour <= '0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            count    <= count_nxt;
            state    <= state_nxt;
            out_plot <= (count_nxt != '0);
            if (count_nxt != '0) {out_x, out_y, out_colour} <= head_word;
            out_done <= (state_nxt == DONE);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_word;
    end

`ifdef PIXEL_CLIP_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic clipped, idle_to_run;
    assign clipped     = in_plot && !in_range;
    assign idle_to_run = (state == IDLE) && (state_nxt == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n)
            clip_count <= '0;
        else if (idle_to_run)
            clip_count <= clipped ? 16'd1 : 16'd0;
        else if (clipped)
            clip_count <= sat_inc(clip_count);
    end
`endif

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Self-checking bench for pixel_clip_fifo: vector table plus scoreboarded corner sequences.
module tb_pixel_clip_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic       in_plot, in_done, out_ready;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_plot, out_done, overflow;
`ifdef PIXEL_CLIP_STATS_EN
    logic [15:0] clip_count;
`endif

    pixel_clip_fifo #(.DEPTH(8), .X_MAX(159), .Y_MAX(119)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_plot(in_plot), .in_done(in_done), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .out_plot(out_plot), .out_done(out_done), .overflow(overflow)
`ifdef PIXEL_CLIP_STATS_EN
        , .clip_count(clip_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         acc;
    } vec_t;

    vec_t        vecs[10];
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every transfer the DUT offers is compared against the oldest expected pixel.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_plot === 1'b1 && out_ready === 1'b1) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop: got %0h expected none", {out_x, out_y, out_colour});
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("pop_data", 32'({out_x, out_y, out_colour}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_plot = 1'b0; in_done = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c, input bit acc);
        in_x = x; in_y = y; in_colour = c; in_plot = 1'b1;
        if (acc) exp_q.push_back({x, y, c});
        tick();
        in_plot = 1'b0;
    endtask

    task automatic drain(input int exp_n);
        int start;
        start = n_pops;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        check("drain_count", 32'(n_pops - start), 32'(exp_n));
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_plot", 32'(out_plot), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_clip;
        vecs[0] = '{8'd160, 7'd10,  3'd1, 1'b0};
        vecs[1] = '{8'd10,  7'd120, 3'd2, 1'b0};
        vecs[2] = '{8'd200, 7'd127, 3'd3, 1'b0};
        vecs[3] = '{8'd159, 7'd119, 3'd4, 1'b1};
        vecs[4] = '{8'd0,   7'd0,   3'd7, 1'b1};
        vecs[5] = '{8'd255, 7'd127, 3'd1, 1'b0};
        vecs[6] = '{8'd159, 7'd0,   3'd5, 1'b1};
        vecs[7] = '{8'd160, 7'd119, 3'd4, 1'b0};
        vecs[8] = '{8'd0,   7'd119, 3'd3, 1'b1};
        vecs[9] = '{8'd159, 7'd120, 3'd6, 1'b0};

        in_x = '0; in_y = '0; in_colour = '0; in_plot = 1'b0; in_done = 1'b0;
        out_ready = 1'b0; rst_n = 1'b0;

        // Reset state
        do_reset();
        check("rst_out_plot", 32'(out_plot), 32'd0);
        check("rst_out_done", 32'(out_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_colour", 32'(out_colour), 32'd0);

        // Single pixel through an empty FIFO
        out_ready = 1'b1;
        send(8'd80, 7'd60, 3'd2, 1'b1);
        check("single_plot", 32'(out_plot), 32'd1);
        check("single_x", 32'(out_x), 32'd80);
        check("single_y", 32'(out_y), 32'd60);
        check("single_colour", 32'(out_colour), 32'd2);
        tick();
        check("single_plot_after", 32'(out_plot), 32'd0);

        // Clipping table, streamed one pixel per cycle
        do_reset();
        out_ready = 1'b1;
        exp_clip = 0;
        for (int i = 0; i < 10; i++) begin
            in_x = vecs[i].x; in_y = vecs[i].y; in_colour = vecs[i].c; in_plot = 1'b1;
            if (vecs[i].acc) exp_q.push_back({vecs[i].x, vecs[i].y, vecs[i].c});
            else exp_clip++;
            tick();
            check($sformatf("clip_vec%0d_plot", i), 32'(out_plot), 32'(vecs[i].acc));
`ifdef PIXEL_CLIP_STATS_EN
            check($sformatf("clip_vec%0d_count", i), 32'(clip_count), 32'(exp_clip));
`endif
        end
        in_plot = 1'b0;
        tick();
        check("clip_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(8'(10 + i), 7'(20 + i), 3'(i), i < 8);
            if (i == 7) check("ovf_before_full_push", 32'(overflow), 32'd0);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head_plot", 32'(out_plot), 32'd1);
        check("ovf_head_x", 32'(out_x), 32'd10);
        tick();
        check("ovf_hold_x", 32'(out_x), 32'd10);
        check("ovf_hold_y", 32'(out_y), 32'd20);
        drain(8);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop at full
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(30 + i), 7'(40 + i), 3'(7 - i), 1'b1);
        out_ready = 1'b1;
        send(8'd50, 7'd50, 3'd5, 1'b1);
        out_ready = 1'b0;
        check("full_pushpop_no_ovf", 32'(overflow), 32'd0);
        tick();
        drain(8);
        check("full_pushpop_no_ovf_end", 32'(overflow), 32'd0);

        // Done handshake
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(100 + i), 7'(i), 3'(i + 1), 1'b1);
        in_done = 1'b1;
        tick();
        tick();
        check("done_wait_done", 32'(out_done), 32'd0);
        check("done_wait_plot", 32'(out_plot), 32'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("done_last_pop_q", 32'(exp_q.size()), 32'd0);
        check("done_last_pop_done", 32'(out_done), 32'd0);
        check("done_last_pop_plot", 32'(out_plot), 32'd0);
        tick();
        check("done_asserted", 32'(out_done), 32'd1);
        send(8'd5, 7'd5, 3'd1, 1'b1);
        check("done_reenter_done", 32'(out_done), 32'd0);
        check("done_reenter_plot", 32'(out_plot), 32'd1);
        tick();
        check("done_reenter_wait", 32'(out_done), 32'd0);
        tick();
        check("done_reasserted", 32'(out_done), 32'd1);
        in_done = 1'b0;
        tick();
        check("done_released", 32'(out_done), 32'd0);

        // Reset in the middle of a drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(60 + i), 7'(70 + i), 3'(i), 1'b1);
        in_done = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("midrst_plot", 32'(out_plot), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_done", 32'(out_done), 32'd0);
        out_ready = 1'b1;
        tick();
        check("midrst_empty_plot", 32'(out_plot), 32'd0);
        check("midrst_drain_state", 32'(out_done), 32'd0);
        tick();
        check("midrst_done_after_idle", 32'(out_done), 32'd1);
        in_done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pixel_clip_fifo.md
PIXEL_CLIP_FIFO -- requirements
Module: pixel_clip_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter X_MAX, default 159, largest on-screen x.
REQ-003 SHALL have parameter Y_MAX, default 119, largest on-screen y.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_x  input  8  pixel x from the upstream circle drawer.
REQ-007 SHALL have port in_y  input  7  pixel y from the upstream circle drawer.
REQ-008 SHALL have port in_colour  input  3  pixel colour.
REQ-009 SHALL have port in_plot  input  1  pixel valid, one pixel per cycle, no backpressure.
REQ-010 SHALL have port in_done  input  1  upstream drawing finished (level).
REQ-011 SHALL have port out_ready  input  1  downstream VGA adapter can accept a pixel.
REQ-012 SHALL have port out_x  output  8  head-of-FIFO x.
REQ-013 SHALL have port out_y  output  7  head-of-FIFO y.
REQ-014 SHALL have port out_colour  output  3  head-of-FIFO colour.
REQ-015 SHALL have port out_plot  output  1  head valid; pixel transferred when out_plot and out_ready are both high.
REQ-016 SHALL have port out_done  output  1  all accepted pixels drained after in_done.
REQ-017 SHALL have port overflow  output  1  sticky, a valid on-screen pixel was dropped because FIFO full.

Function
REQ-018 SHALL clip: pixel accepted only if in_plot=1, in_x<=X_MAX and in_y<=Y_MAX; others discarded silently.
REQ-019 SHALL push an accepted pixel when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL pop when out_plot=1 and out_ready=1; head advances on that edge.
REQ-021 SHALL present out_x/out_y/out_colour/out_plot as registered values; latency in_plot to out_plot is exactly 1 cycle into an empty FIFO.
REQ-022 SHALL hold out_x/out_y/out_colour stable while out_plot=1 and out_ready=0.
REQ-023 SHALL keep out_plot=0 when FIFO empty; out_x/out_y/out_colour then hold last value.
REQ-024 SHALL, on push to full FIFO with no pop, drop the pixel, keep contents intact, and set overflow=1 until reset.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count width log2(DEPTH)+1 bits, never exceeds DEPTH or underflows.
REQ-026 SHALL implement FSM IDLE, RUN, DRAIN, DONE: IDLE->RUN on in_plot; IDLE or RUN->DRAIN on in_done=1; DRAIN->DONE when count=0 and no push this cycle; DONE->IDLE when in_done=0.
REQ-027 SHALL drive out_done=1 only in DONE, registered.
REQ-028 SHALL still accept in-range pixels in DRAIN; in DONE an in_plot with in_done=1 SHALL be accepted and return FSM to DRAIN.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, empty the FIFO, zero pointers and count, enter IDLE, and drive out_plot=0, out_done=0, overflow=0, out_x=0, out_y=0, out_colour=0.
REQ-030 SHALL give reset priority over push and pop in the same cycle; reset mid-drain discards all queued pixels.

Configuration
REQ-031 SHALL, with macro PIXEL_CLIP_STATS_EN defined, add output clip_count (16 bits) counting pixels discarded by REQ-018 with in_plot=1, saturating at 65535, cleared by reset and on IDLE->RUN.
REQ-032 SHALL, without PIXEL_CLIP_STATS_EN, omit clip_count port and its counter entirely; all other behaviour identical.

Verification
REQ-033 SHALL verify single pixel: empty FIFO, in_plot with (80,60,2), out_ready=1 -> out_plot=1 with (80,60,2) next cycle, out_plot=0 the cycle after.
REQ-034 SHALL verify clipping: pixels (160,10), (10,120), (200,127), (159,119) -> only (159,119) appears; clip_count=3 when PIXEL_CLIP_STATS_EN.
REQ-035 SHALL verify backpressure/overflow: out_ready=0, 9 valid pixels at DEPTH=8 -> first 8 retained in order, overflow=1; out_ready=1 drains exactly 8 in order.
REQ-036 SHALL verify simultaneous push/pop at full: count=8, out_ready=1, push -> no overflow, count stays 8, FIFO order preserved.
REQ-037 SHALL verify done: 3 pixels queued, out_ready=0, in_done=1 -> out_done=0; out_ready=1 -> out_done=1 one cycle after last pop; in_done=0 -> out_done=0 next cycle.
REQ-038 SHALL verify reset mid-drain: 5 queued, rst_n=0 one cycle -> out_plot=0, overflow=0, FIFO empty, FSM IDLE.
